// File: rtl/addsub_accumulator_pkg.sv
// Shared encodings for the add/subtract accumulator: operation codes and
// controller state values.
package addsub_accumulator_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/adder_subtractor_nbit.sv
// Combinational n-bit adder/subtractor: s = x + y when add_n = 0,
// s = x - y (two's complement) when add_n = 1. Result wraps modulo 2^n.
module adder_subtractor_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         add_n,
    output logic [n-1:0] s
);

    assign s = x + (y ^ {n{add_n}}) + {{(n-1){1'b0}}, add_n};

endmodule

// File: rtl/addsub_accumulator.sv
// Sequential front-end for the add/subtract datapath: accepts one operation,
// updates the accumulator and flags, and holds the result until it is taken.
module addsub_accumulator
    import addsub_accumulator_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [n-1:0] operand,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] acc,
    output logic         carry,
    output logic         ovf,
    output logic         zero,
    output logic         neg,
    output logic [7:0]   op_count,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE; out_valid is high only in DONE,
    // and acc/flags stay constant for as long as out_valid is high.

    state_t       state, next_state;
    logic [1:0]   op_q;
    logic [n-1:0] operand_q;

    logic         sub;
    logic [n-1:0] y_eff;
    logic [n-1:0] dp_sum;
    logic         msb_cin;
    logic         sum_c;
    logic         sum_msb;

    logic [n-1:0] res_acc;
    logic         res_carry;
    logic         res_ovf;

    assign sub   = (op_q == OP_SUB);
    assign y_eff = operand_q ^ {n{sub}};

    adder_subtractor_nbit #(.n(n)) u_addsub (
        .x     (acc),
        .y     (operand_q),
        .add_n (sub),
        .s     (dp_sum)
    );

    // The top bit of the (n+1)-bit sum acc + y_eff + sub is rebuilt from the
    // MSB inputs and the carry into the MSB, so no datapath carry port is needed.
    assign msb_cin            = dp_sum[n-1] ^ acc[n-1] ^ y_eff[n-1];
    assign {sum_c, sum_msb}   = {1'b0, acc[n-1]} + {1'b0, y_eff[n-1]} + {1'b0, msb_cin};

    always_comb begin
        res_acc   = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (op_q)
            OP_LOAD: res_acc = operand_q;
            OP_ADD, OP_SUB: begin
                res_acc   = dp_sum;
                res_carry = sum_c;
                res_ovf   = (acc[n-1] == y_eff[n-1]) & (sum_msb != acc[n-1]);
            end
            default: res_acc = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid) next_state = S_EXEC;
            S_EXEC:  next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            op_q      <= OP_LOAD;
            operand_q <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && in_valid) begin
                op_q      <= op;
                operand_q <= operand;
            end
            if (state == S_EXEC) begin
                acc      <= res_acc;
                carry    <= res_carry;
                ovf      <= res_ovf;
                zero     <= (res_acc == '0);
                neg      <= res_acc[n-1];
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator (n = 4) with hand-computed expected
// results, an expected-acc queue and a one-line summary.
module tb_addsub_accumulator;
    import addsub_accumulator_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [N-1:0] operand;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] acc;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         neg;
    logic [7:0]   op_count;
    logic [1:0]   dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    logic [N-1:0] exp_q[$];

    addsub_accumulator #(.n(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg),
        .op_count  (op_count),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic e_c, input logic e_o,
                                input logic [7:0] e_cnt);
        logic [N-1:0] e_acc;
        if (exp_q.size() == 0) begin
            check({tag, ".sb_underflow"}, 32'(1), 32'(0));
        end else begin
            e_acc = exp_q.pop_front();
            check({tag, ".acc"},   32'(acc),   32'(e_acc));
            check({tag, ".zero"},  32'(zero),  32'(e_acc == '0));
            check({tag, ".neg"},   32'(neg),   32'(e_acc[N-1]));
        end
        check({tag, ".carry"}, 32'(carry), 32'(e_c));
        check({tag, ".ovf"},   32'(ovf),   32'(e_o));
        check({tag, ".count"}, 32'(op_count), 32'(e_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst.acc",       32'(acc),       32'(0));
        check("rst.flags",     32'({carry, ovf, zero, neg}), 32'(0));
        check("rst.count",     32'(op_count),  32'(0));
        check("rst.out_valid", 32'(out_valid), 32'(0));
        check("rst.in_ready",  32'(in_ready),  32'(1));
        check("rst.state",     32'(dbg_state), 32'(S_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Starts and ends at a negedge with the DUT in IDLE.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [N-1:0] d,
                         input logic [N-1:0] e_acc, input logic e_c, input logic e_o,
                         input logic [7:0] e_cnt);
        exp_q.push_back(e_acc);
        op       = o;
        operand  = d;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".exec_valid"}, 32'(out_valid), 32'(0));
        check({tag, ".exec_ready"}, 32'(in_ready),  32'(0));
        @(posedge clk);
        @(negedge clk);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(1));
        check_result(tag, e_c, e_o, e_cnt);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".released"}, 32'(out_valid), 32'(0));
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = OP_LOAD;
        operand   = '0;

        do_reset();
        do_op("load7",  OP_LOAD, 4'd7, 4'd7,    1'b0, 1'b0, 8'd1);
        do_op("add1",   OP_ADD,  4'd1, 4'b1000, 1'b0, 1'b1, 8'd2);
        do_op("load8",  OP_LOAD, 4'd8, 4'd8,    1'b0, 1'b0, 8'd3);
        do_op("sub3",   OP_SUB,  4'd3, 4'b0101, 1'b1, 1'b1, 8'd4);
        do_op("load2",  OP_LOAD, 4'd2, 4'd2,    1'b0, 1'b0, 8'd5);
        do_op("sub5",   OP_SUB,  4'd5, 4'b1101, 1'b0, 1'b0, 8'd6);

        do_reset();
        do_op("load15", OP_LOAD,  4'd15, 4'd15, 1'b0, 1'b0, 8'd1);
        do_op("add1w",  OP_ADD,   4'd1,  4'd0,  1'b1, 1'b0, 8'd2);
        do_op("clear",  OP_CLEAR, 4'd9,  4'd0,  1'b0, 1'b0, 8'd3);

        // back-pressure: result of ADD 2 held while a new request waits
        do_op("load3",  OP_LOAD, 4'd3, 4'd3, 1'b0, 1'b0, 8'd4);
        exp_q.push_back(4'd5);
        op       = OP_ADD;
        operand  = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        operand = 4'd1;
        @(posedge clk);
        @(negedge clk);
        check_result("bp.add2", 1'b0, 1'b0, 8'd5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp.hold_acc",   32'(acc),       32'(5));
            check("bp.hold_valid", 32'(out_valid), 32'(1));
            check("bp.hold_ready", 32'(in_ready),  32'(0));
            check("bp.hold_count", 32'(op_count),  32'(5));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.idle_ready", 32'(in_ready), 32'(1));
        exp_q.push_back(4'd6);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.accepted", 32'(in_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("bp.valid2", 32'(out_valid), 32'(1));
        check_result("bp.add1", 1'b0, 1'b0, 8'd6);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // reset while ADD 5 is in EXEC
        do_reset();
        op       = OP_ADD;
        operand  = 4'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("abort.in_exec", 32'(dbg_state), 32'(S_EXEC));
        reset_n = 1'b0;
        #1;
        check("abort.acc",       32'(acc),       32'(0));
        check("abort.out_valid", 32'(out_valid), 32'(0));
        check("abort.count",     32'(op_count),  32'(0));
        @(posedge clk);
        @(negedge clk);
        check("abort.still_acc", 32'(acc),      32'(0));
        check("abort.in_ready",  32'(in_ready), 32'(1));
        reset_n = 1'b1;
        do_op("after_abort", OP_LOAD, 4'd9, 4'd9, 1'b0, 1'b0, 8'd1);

        // op_count wraps 255 -> 0
        for (int i = 0; i < 255; i++) begin
            do_op("wrap", OP_CLEAR, 4'd3, 4'd0, 1'b0, 1'b0, 8'(i + 2));
        end
        check("wrap.final", 32'(op_count), 32'(0));
        check("sb.empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
